uart_rx_cfg: RTL and testbench
==============================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50_000_000, giving the i_clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 9600, giving the line rate in bit/s.
REQ-003 The block SHALL have parameter OVERSAMPLE, default 16, giving the ticks per bit period; it must be even and at least 8.
REQ-004 The block SHALL have parameter DATA_BITS, default 8, giving the data bits per frame; legal range is 5..9.
REQ-005 The block SHALL have parameter PARITY, default 0, where 0 = none, 1 = odd, 2 = even.
REQ-006 The block SHALL have parameter STOP_BITS, default 1, giving the stop bits per frame; legal values are 1 and 2.
REQ-007 The block SHALL have port i_clock, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-008 The block SHALL have port i_reset, input, 1 bit: asynchronous, active-low reset.
REQ-009 The block SHALL have port i_rx, input, 1 bit: asynchronous serial line, idle high.
REQ-010 The block SHALL have port i_ready, input, 1 bit: consumer accepts the held word.
REQ-011 The block SHALL have port o_data, output, DATA_BITS wide: received word, LSB first on the line.
REQ-012 The block SHALL have port o_valid, output, 1 bit: the held word is available.
REQ-013 The block SHALL have port o_parity_err, output, 1 bit: parity mismatch on the held word.
REQ-014 The block SHALL have port o_frame_err, output, 1 bit: a stop bit was sampled low on the held word.
REQ-015 The block SHALL have port o_overrun, output, 1 bit: one-cycle pulse when a frame is dropped.
REQ-016 The block SHALL have port o_busy, output, 1 bit: the FSM is not in IDLE.

Function
REQ-017 The tick generator SHALL pulse one cycle every DIV = floor(CLK_FREQ/(BAUD_RATE*OVERSAMPLE)) clocks, counter width $clog2(DIV), free-running.
REQ-018 i_rx SHALL pass through a 2-FF synchronizer preset to 1; all FSM decisions SHALL use the synchronized value.
REQ-019 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-020 IDLE -> START SHALL occur on a synchronized high-to-low transition; a line held low does not retrigger.
REQ-021 In START, after OVERSAMPLE/2 ticks, a low line SHALL go to DATA; a high line SHALL return to IDLE (glitch reject, no outputs change).
REQ-022 In DATA, the line SHALL be sampled every OVERSAMPLE ticks into a shift register, LSB first, for DATA_BITS samples.
REQ-023 After DATA, the FSM SHALL go to PARITY when PARITY != 0, else to STOP.
REQ-024 PARITY SHALL sample once after OVERSAMPLE ticks; err = (XOR(data) ^ bit) != (PARITY==1).
REQ-025 STOP SHALL sample STOP_BITS times, OVERSAMPLE ticks apart; any low sample SHALL set the frame error.
REQ-026 After the last stop sample, the FSM SHALL return to IDLE at mid-stop-bit.
REQ-027 On completion with o_valid=0, the word and both error flags SHALL load the holding register and o_valid SHALL rise the next clock.
REQ-028 o_valid, o_data, o_parity_err and o_frame_err SHALL hold stable until a clock with o_valid & i_ready, which clears o_valid.
REQ-029 If a frame completes while o_valid=1 and i_ready=0, the held word SHALL be preserved, the new frame dropped, and o_overrun pulse for 1 clock.
REQ-030 If i_ready=1 in the same clock a frame completes, the old word SHALL be consumed and the new one loaded with no overrun.
REQ-031 Frames with errors SHALL still be delivered, with their flags set.

Reset
REQ-032 While i_reset=0, the FSM SHALL be in IDLE, all counters 0, synchronizer 1, and every output 0.
REQ-033 A reset asserted mid-frame SHALL abandon the frame, with no o_valid after release.
REQ-034 After release, reception SHALL start only on a fresh falling edge.

Verification (CLK_FREQ=1_600_000, BAUD_RATE=10_000, OVERSAMPLE=16 -> DIV=10, bit = 160 clocks)
REQ-035 Reset and idle: hold i_reset=0, then release with i_rx=1 for 2000 clocks -> all outputs 0 throughout.
REQ-036 8N1 good frame: send 0x04 with i_ready=0 -> o_data=0x04, o_valid=1, both error flags 0, o_valid held until i_ready=1, then clears the next clock.
REQ-037 PARITY=2, 8 bits: send 0xA5 with parity bit 1 -> o_parity_err=1; send 0xA5 with parity bit 0 -> o_parity_err=0.
REQ-038 Framing error and break: send 0x55 with stop=0, then hold the line low for 3000 clocks -> exactly one o_valid with o_frame_err=1, and no retrigger until the line goes high and falls again.
REQ-039 Glitch reject: drive i_rx low for 40 clocks -> o_busy rises then returns to 0, and no o_valid.
REQ-040 Overrun and reset: send 0x11 then 0x22 with i_ready=0 -> o_data=0x11 and one o_overrun pulse; then pulse i_reset=0 mid-frame -> all outputs 0 and no o_valid for that frame.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampling UART receiver with configurable frame format
// (data bits, parity, stop bits) and a one-word valid/ready holding register.
module uart_rx_cfg #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_rx,
    input  logic                 i_ready,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_busy
);

    localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  FULL_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);
    localparam logic             HAS_PAR   = (PARITY != 0);
    localparam logic             ODD_PAR   = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // state is left as a named enum so checkers can bind to it directly
    state_t state, state_next;

    logic [DIV_W-1:0]     div_cnt;
    logic                 tick;
    logic                 rx_meta, rx_sync, rx_prev;
    logic                 fall;
    logic [OS_W-1:0]      os_cnt;
    logic                 os_done;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 stop_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_err_r, frame_err_r;
    logic                 frame_start, sample_data, sample_par, sample_stop, frame_done;

    // free-running oversample tick generator
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset)                div_cnt <= '0;
        else if (div_cnt == DIV_LAST) div_cnt <= '0;
        else                         div_cnt <= div_cnt + DIV_W'(1);
    end

    assign tick = (div_cnt == DIV_LAST);

    // 2-FF synchronizer plus one history flop for edge detection, all preset to idle-high
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign fall    = rx_prev & ~rx_sync;
    assign os_done = tick && (os_cnt == ((state == S_START) ? HALF_LAST : FULL_LAST));

    // FSM state register
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) state <= S_IDLE;
        else          state <= state_next;
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (fall) state_next = S_START;
            S_START:  if (os_done) state_next = rx_sync ? S_IDLE : S_DATA;
            S_DATA:   if (os_done && bit_cnt == DATA_LAST)
                          state_next = HAS_PAR ? S_PARITY : S_STOP;
            S_PARITY: if (os_done) state_next = S_STOP;
            S_STOP:   if (os_done && stop_cnt == STOP_LAST) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // FSM outputs: sample strobes and frame boundaries
    always_comb begin
        o_busy      = (state != S_IDLE);
        frame_start = (state == S_IDLE) && fall;
        sample_data = (state == S_DATA) && os_done;
        sample_par  = (state == S_PARITY) && os_done;
        sample_stop = (state == S_STOP) && os_done;
        frame_done  = sample_stop && (stop_cnt == STOP_LAST);
    end

    // tick, bit and stop-bit counters
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            os_cnt   <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
        end else begin
            if (state == S_IDLE || os_done) os_cnt <= '0;
            else if (tick)                  os_cnt <= os_cnt + OS_W'(1);

            if (state != S_DATA)  bit_cnt <= '0;
            else if (sample_data) bit_cnt <= bit_cnt + BIT_W'(1);

            if (state != S_STOP)  stop_cnt <= 1'b0;
            else if (sample_stop) stop_cnt <= ~stop_cnt;
        end
    end

    // shift register (LSB arrives first) and per-frame error flags
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            shreg       <= '0;
            par_err_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            if (sample_data) shreg <= {rx_sync, shreg[DATA_BITS-1:1]};

            if (frame_start)     par_err_r <= 1'b0;
            else if (sample_par) par_err_r <= ((^shreg) ^ rx_sync) != ODD_PAR;

            if (frame_start)                  frame_err_r <= 1'b0;
            else if (sample_stop && !rx_sync) frame_err_r <= 1'b1;
        end
    end

    // Holding register handshake: a word transfers on any clock where
    // o_valid & i_ready; o_data/flags hold while o_valid is high. A finished
    // frame loads when the register is empty or being drained that same clock,
    // otherwise it is dropped and o_overrun pulses for one clock.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_overrun <= 1'b0;
            if (frame_done) begin
                if (!o_valid || i_ready) begin
                    o_data       <= shreg;
                    o_parity_err <= par_err_r;
                    o_frame_err  <= frame_err_r | ~rx_sync;
                    o_valid      <= 1'b1;
                end else begin
                    o_overrun <= 1'b1;
                end
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: an 8N1 instance and an 8E1 instance share
// clock and reset; each step drives the line and checks hand-computed values.
module tb_uart_rx_cfg;

    localparam int BIT_CLKS = 160;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_n, rx_p;
    logic       ready_n, ready_p;
    logic [7:0] data_n, data_p;
    logic       valid_n, valid_p, perr_n, perr_p, ferr_n, ferr_p;
    logic       ovr_n, ovr_p, busy_n, busy_p;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] exp_q[$];

    int   vrise_n   = 0;
    int   ovr_cnt_n = 0;
    logic valid_n_q = 1'b0;
    logic quiet_win = 1'b0;
    logic quiet_bad = 1'b0;

    int base_v, base_o;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLE(16),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_n (
        .i_clock(clk), .i_reset(rst_n), .i_rx(rx_n), .i_ready(ready_n),
        .o_data(data_n), .o_valid(valid_n), .o_parity_err(perr_n),
        .o_frame_err(ferr_n), .o_overrun(ovr_n), .o_busy(busy_n)
    );

    uart_rx_cfg #(.CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLE(16),
                  .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_p (
        .i_clock(clk), .i_reset(rst_n), .i_rx(rx_p), .i_ready(ready_p),
        .o_data(data_p), .o_valid(valid_p), .o_parity_err(perr_p),
        .o_frame_err(ferr_p), .o_overrun(ovr_p), .o_busy(busy_p)
    );

    // event counters and quiet-window watcher, sampled on the falling edge
    always @(negedge clk) begin
        if (valid_n && !valid_n_q) vrise_n++;
        if (ovr_n) ovr_cnt_n++;
        valid_n_q = valid_n;
        if (quiet_win && (valid_n || ovr_n || busy_n || perr_n || ferr_n || data_n != 8'h00 ||
                          valid_p || ovr_p || busy_p || perr_p || ferr_p || data_p != 8'h00))
            quiet_bad = 1'b1;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_data(input string tag, input logic [7:0] obs);
        logic [7:0] exp;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s: observed=%0h expected=<empty queue>", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            check(tag, {24'h0, obs}, {24'h0, exp});
        end
    endtask

    task automatic send_n(input logic [7:0] d, input logic stop);
        rx_n = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx_n = d[i];
            wait_clks(BIT_CLKS);
        end
        rx_n = stop;
        wait_clks(BIT_CLKS);
    endtask

    task automatic send_p(input logic [7:0] d, input logic par);
        rx_p = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx_p = d[i];
            wait_clks(BIT_CLKS);
        end
        rx_p = par;
        wait_clks(BIT_CLKS);
        rx_p = 1'b1;
        wait_clks(BIT_CLKS);
    endtask

    task automatic consume_p();
        ready_p = 1'b1;
        wait_clks(1);
        ready_p = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        rx_n    = 1'b1;
        rx_p    = 1'b1;
        ready_n = 1'b0;
        ready_p = 1'b0;

        // reset and idle
        wait_clks(20);
        check("rst_valid", {31'h0, valid_n}, 32'h0);
        check("rst_data", {24'h0, data_n}, 32'h0);
        check("rst_busy", {31'h0, busy_n}, 32'h0);
        check("rst_flags", {29'h0, perr_n, ferr_n, ovr_n}, 32'h0);
        quiet_win = 1'b1;
        rst_n     = 1'b1;
        wait_clks(2000);
        quiet_win = 1'b0;
        check("idle_quiet", {31'h0, quiet_bad}, 32'h0);

        // 8N1 good frame, held until consumed
        exp_q.push_back(8'h04);
        send_n(8'h04, 1'b1);
        check("good_valid", {31'h0, valid_n}, 32'h1);
        check_data("good_data", data_n);
        check("good_errs", {30'h0, perr_n, ferr_n}, 32'h0);
        wait_clks(300);
        check("good_hold_valid", {31'h0, valid_n}, 32'h1);
        check("good_hold_data", {24'h0, data_n}, 32'h04);
        ready_n = 1'b1;
        wait_clks(1);
        ready_n = 1'b0;
        check("good_cleared", {31'h0, valid_n}, 32'h0);

        // even parity: 0xA5 has four ones, so parity bit 1 is wrong, 0 is right
        exp_q.push_back(8'hA5);
        send_p(8'hA5, 1'b1);
        check("par1_valid", {31'h0, valid_p}, 32'h1);
        check_data("par1_data", data_p);
        check("par1_perr", {31'h0, perr_p}, 32'h1);
        check("par1_ferr", {31'h0, ferr_p}, 32'h0);
        consume_p();
        exp_q.push_back(8'hA5);
        send_p(8'hA5, 1'b0);
        check("par0_valid", {31'h0, valid_p}, 32'h1);
        check_data("par0_data", data_p);
        check("par0_perr", {31'h0, perr_p}, 32'h0);
        consume_p();

        // framing error followed by a break
        base_v = vrise_n;
        exp_q.push_back(8'h55);
        send_n(8'h55, 1'b0);
        wait_clks(3000);
        check("brk_vrise", vrise_n - base_v, 32'd1);
        check("brk_busy", {31'h0, busy_n}, 32'h0);
        check_data("brk_data", data_n);
        check("brk_ferr", {31'h0, ferr_n}, 32'h1);
        check("brk_perr", {31'h0, perr_n}, 32'h0);
        ready_n = 1'b1;
        wait_clks(1);
        ready_n = 1'b0;
        rx_n = 1'b1;
        wait_clks(200);
        check("brk_release_busy", {31'h0, busy_n}, 32'h0);
        exp_q.push_back(8'h3C);
        send_n(8'h3C, 1'b1);
        check_data("after_brk_data", data_n);
        check("after_brk_ferr", {31'h0, ferr_n}, 32'h0);
        ready_n = 1'b1;
        wait_clks(1);
        ready_n = 1'b0;

        // glitch reject
        wait_clks(200);
        base_v = vrise_n;
        rx_n = 1'b0;
        wait_clks(30);
        check("glitch_busy_hi", {31'h0, busy_n}, 32'h1);
        wait_clks(10);
        rx_n = 1'b1;
        wait_clks(200);
        check("glitch_busy_lo", {31'h0, busy_n}, 32'h0);
        check("glitch_no_valid", {31'h0, valid_n}, 32'h0);
        check("glitch_vrise", vrise_n - base_v, 32'd0);

        // overrun: second frame is dropped, first is kept
        base_o = ovr_cnt_n;
        exp_q.push_back(8'h11);
        send_n(8'h11, 1'b1);
        send_n(8'h22, 1'b1);
        wait_clks(100);
        check("ovr_valid", {31'h0, valid_n}, 32'h1);
        check_data("ovr_data", data_n);
        check("ovr_pulses", ovr_cnt_n - base_o, 32'd1);

        // reset mid-frame
        rx_n = 1'b0;
        wait_clks(BIT_CLKS);
        rx_n = 1'b1;
        wait_clks(BIT_CLKS * 2);
        check("mid_busy", {31'h0, busy_n}, 32'h1);
        rst_n = 1'b0;
        wait_clks(5);
        check("mid_rst_valid", {31'h0, valid_n}, 32'h0);
        check("mid_rst_data", {24'h0, data_n}, 32'h0);
        check("mid_rst_busy", {31'h0, busy_n}, 32'h0);
        check("mid_rst_flags", {29'h0, perr_n, ferr_n, ovr_n}, 32'h0);
        rst_n = 1'b1;
        base_v = vrise_n;
        wait_clks(2000);
        check("post_rst_vrise", vrise_n - base_v, 32'd0);
        check("post_rst_busy", {31'h0, busy_n}, 32'h0);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
